// File: rtl/rx_deserializer_if.sv
// Sampler-to-deserializer bundle: bit strobe and frame controls in, frame data and status out.
interface rx_deserializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  sampled_bit;
  logic                  deser_en;
  logic                  frame_start;
  logic                  par_en;
  logic                  par_typ;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;

  modport master (
    output sampled_bit, deser_en, frame_start, par_en, par_typ,
    input  P_DATA, data_valid, par_err, stp_err, busy
  );

  modport slave (
    input  sampled_bit, deser_en, frame_start, par_en, par_typ,
    output P_DATA, data_valid, par_err, stp_err, busy
  );
endinterface

// File: rtl/rx_deserializer.sv
// Serial-to-parallel frame collector with optional parity check and stop-bit check.
//   state  | meaning
//   IDLE   | waiting for frame_start, bit strobes ignored
//   DATA   | collecting DATA_WIDTH data bits
//   PARITY | waiting for the parity bit
//   STOP   | waiting for the stop bit; frame result is published here
module rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input logic            clk,
  input logic            rst,
  rx_deserializer_if.slave rx
);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         idx;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  perr_int_q, perr_int_d;
  logic                  valid_q, valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      p_data_q   <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      perr_int_q <= 1'b0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      p_data_q   <= p_data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      perr_int_q <= perr_int_d;
      valid_q    <= valid_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    p_data_d   = p_data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    perr_int_d = perr_int_q;
    valid_d    = 1'b0;
    par_err_d  = par_err_q;
    stp_err_d  = stp_err_q;
    idx        = MSB_FIRST ? (CW'(DATA_WIDTH - 1) - cnt_q) : cnt_q;

    // frame_start restarts from any state and masks a coincident strobe
    if (rx.frame_start) begin
      state_d    = DATA;
      cnt_d      = '0;
      shift_d    = '0;
      par_en_d   = rx.par_en;
      par_typ_d  = rx.par_typ;
      perr_int_d = 1'b0;
    end else begin
      case (state_q)
        DATA: begin
          if (rx.deser_en) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
              if (idx == CW'(i)) shift_d[i] = rx.sampled_bit;
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(DATA_WIDTH - 1)) state_d = par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (rx.deser_en) begin
            perr_int_d = (^shift_q) ^ par_typ_q ^ rx.sampled_bit;
            state_d    = STOP;
          end
        end
        STOP: begin
          if (rx.deser_en) begin
            p_data_d  = shift_q;
            par_err_d = par_en_q & perr_int_q;
            stp_err_d = ~rx.sampled_bit;
            valid_d   = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rx.P_DATA     = p_data_q;
  assign rx.data_valid = valid_q;
  assign rx.par_err    = par_err_q;
  assign rx.stp_err    = stp_err_q;
  assign rx.busy       = (state_q != IDLE);
endmodule
